// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: FSM state type, IV, K round constants and
// the bitwise helper functions used by the compression and schedule stages.
package sha256_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_FINAL = 2'd2
  } state_e;

  // {H0..H7}, H0 in the top word
  localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] k_const(input logic [5:0] t);
    return K_TAB[t];
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, y, z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, y, z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] ep0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] ep1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_compress_core_round.sv
// One combinational SHA-256 compression round.
// Ports: a_i..h_i working variables, k_i round constant, w_i schedule word;
//        a_o..h_o working variables after the round.
module sha256_round
  import sha256_pkg::*;
(
  input  logic [31:0] a_i, b_i, c_i, d_i, e_i, f_i, g_i, h_i,
  input  logic [31:0] k_i,
  input  logic [31:0] w_i,
  output logic [31:0] a_o, b_o, c_o, d_o, e_o, f_o, g_o, h_o
);

  logic [31:0] t1, t2;

  always_comb begin
    t1  = h_i + ep1(e_i) + ch(e_i, f_i, g_i) + k_i + w_i;
    t2  = ep0(a_i) + maj(a_i, b_i, c_i);
    a_o = t1 + t2;
    b_o = a_i;
    c_o = b_i;
    d_o = c_i;
    e_o = d_i + t1;
    f_o = e_i;
    g_o = f_i;
    h_o = g_i;
  end

endmodule

// File: rtl/sha256_compress_core.sv
// SHA-256 compression core: consumes W[0..ROUNDS-1] over a valid/ready
// handshake, runs the rounds on a..h and folds the result into H0..H7.
// Ports: clk/rst (sync, active-high); start/use_iv/abort control;
//        w_valid/w_data/w_ready schedule-word input; busy/done/digest_valid
//        status; digest {H0..H7}; round_idx current round for debug.
module sha256_compress_core
  import sha256_pkg::*;
#(
  parameter int ROUNDS = 64,
  parameter int CNT_W  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             use_iv,
  input  logic             abort,
  input  logic             w_valid,
  input  logic [31:0]      w_data,
  output logic             w_ready,
  output logic             busy,
  output logic             done,
  output logic             digest_valid,
  output logic [255:0]     digest,
  output logic [CNT_W-1:0] round_idx
);

  state_e             state_q, state_d;
  logic [255:0]       hs_q, hs_d;   // {H0..H7}
  logic [255:0]       wv_q, wv_d;   // {a..h}
  logic [CNT_W-1:0]   t_q, t_d;
  logic               done_q, done_d;
  logic               dv_q, dv_d;
  logic [255:0]       rnd_next;
  logic               last_word;

  sha256_round u_round (
    .a_i (wv_q[255:224]), .b_i (wv_q[223:192]), .c_i (wv_q[191:160]), .d_i (wv_q[159:128]),
    .e_i (wv_q[127:96]),  .f_i (wv_q[95:64]),   .g_i (wv_q[63:32]),   .h_i (wv_q[31:0]),
    .k_i (k_const(6'(t_q))),
    .w_i (w_data),
    .a_o (rnd_next[255:224]), .b_o (rnd_next[223:192]), .c_o (rnd_next[191:160]), .d_o (rnd_next[159:128]),
    .e_o (rnd_next[127:96]),  .f_o (rnd_next[95:64]),   .g_o (rnd_next[63:32]),   .h_o (rnd_next[31:0])
  );

  assign last_word = (t_q == CNT_W'(ROUNDS - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; abort overrides every transition
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (start) state_d = S_ROUND;
        S_ROUND: if (w_valid && last_word) state_d = S_FINAL;
        S_FINAL: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs decoded from state
  always_comb begin
    w_ready = (state_q == S_ROUND);
    busy    = (state_q == S_ROUND) || (state_q == S_FINAL);
  end

  // Datapath next-state
  always_comb begin
    hs_d   = hs_q;
    wv_d   = wv_q;
    t_d    = t_q;
    done_d = 1'b0;
    dv_d   = dv_q;
    if (abort) begin
      t_d  = '0;
      dv_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (use_iv) begin
              hs_d = IV;
              wv_d = IV;
            end else begin
              wv_d = hs_q;
            end
            t_d  = '0;
            dv_d = 1'b0;
          end
        end
        S_ROUND: begin
          if (w_valid) begin
            wv_d = rnd_next;
            t_d  = t_q + CNT_W'(1);
          end
        end
        S_FINAL: begin
          for (int unsigned i = 0; i < 8; i++) begin
            hs_d[32*i +: 32] = hs_q[32*i +: 32] + wv_q[32*i +: 32];
          end
          done_d = 1'b1;
          dv_d   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q   <= IV;
      wv_q   <= '0;
      t_q    <= '0;
      done_q <= 1'b0;
      dv_q   <= 1'b0;
    end else begin
      hs_q   <= hs_d;
      wv_q   <= wv_d;
      t_q    <= t_d;
      done_q <= done_d;
      dv_q   <= dv_d;
    end
  end

  assign done         = done_q;
  assign digest_valid = dv_q;
  assign digest       = hs_q;
  assign round_idx    = t_q;

endmodule

// File: tb/tb_sha256_compress_core.sv
// Self-checking bench for sha256_compress_core: a SHA-256 reference model
// (K derived from prime cube roots) feeds a scoreboard that a done-driven
// monitor drains; directed checks cover reset, abort and protocol edges.
module tb_sha256_compress_core;

  typedef logic [31:0] blk_t [16];
  typedef logic [31:0] w64_t [64];
  typedef struct { logic [255:0] dig; int unsigned cyc; } exp_t;

  localparam logic [255:0] IV_C    = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic clk = 1'b0;
  logic rst, start, use_iv, abort, w_valid;
  logic [31:0] w_data;
  logic w_ready, busy, done, digest_valid;
  logic [255:0] digest;
  logic [5:0] round_idx;

  int unsigned checks = 0, errors = 0, cyc = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [31:0] kt [64];
  logic [255:0] h_model;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sha256_compress_core #(.ROUNDS(64), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .use_iv(use_iv), .abort(abort),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready), .busy(busy),
    .done(done), .digest_valid(digest_valid), .digest(digest), .round_idx(round_idx)
  );

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] frac32(input real x);
    real f;
    f = x - $floor(x);
    return 32'(longint'($floor(f * 4294967296.0)));
  endfunction

  task automatic init_k();
    int n = 0;
    int p = 2;
    while (n < 64) begin
      bit prime = 1'b1;
      for (int d = 2; d * d <= p; d++) if (p % d == 0) prime = 1'b0;
      if (prime) begin
        kt[n] = frac32($pow(real'(p), 1.0 / 3.0));
        n++;
      end
      p++;
    end
  endtask

  function automatic w64_t expand(input blk_t m);
    w64_t w;
    for (int t = 0; t < 16; t++) w[t] = m[t];
    for (int t = 16; t < 64; t++)
      w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    return w;
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] h, input w64_t w);
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    logic [255:0] r;
    for (int i = 0; i < 8; i++) v[i] = h[255 - 32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + kt[t] + w[t];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = h[255 - 32*i -: 32] + v[i];
    return r;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 required no pending block");
      end else begin
        mon_e = exp_q.pop_front();
        chk("digest", digest, mon_e.dig);
        chk("done_cycle", 256'(cyc), 256'(mon_e.cyc));
        chk("digest_valid_at_done", 256'(digest_valid), 256'(1));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_quiet(input string nm, input logic [255:0] exp_dig);
    @(negedge clk);
    chk({nm, "_busy"}, 256'(busy), 256'(0));
    chk({nm, "_w_ready"}, 256'(w_ready), 256'(0));
    chk({nm, "_done"}, 256'(done), 256'(0));
    chk({nm, "_digest_valid"}, 256'(digest_valid), 256'(0));
    chk({nm, "_round_idx"}, 256'(round_idx), 256'(0));
    chk({nm, "_digest"}, digest, exp_dig);
  endtask

  // Runs one block; returns #1 into the done cycle, or into the cycle
  // after the quiet checks when aborted/reset at word index abort_at/rst_at.
  task automatic run_block(input blk_t m, input bit iv, input bit stall,
                           input int abort_at, input int rst_at, input int spur_at);
    w64_t w;
    bit pat[$];
    int ones = 0;
    int acc = 0;
    int unsigned sc;
    bit ended = 1'b0;
    w = expand(m);
    while (ones < 64) begin
      bit b = stall ? bit'($urandom_range(0, 1)) : 1'b1;
      pat.push_back(b);
      if (b) ones++;
    end
    start = 1'b1;
    use_iv = iv;
    @(posedge clk);
    #1;
    start = 1'b0;
    sc = cyc;
    if (iv) h_model = IV_C;
    if (abort_at < 0 && rst_at < 0) begin
      h_model = compress(h_model, w);
      exp_q.push_back('{dig: h_model, cyc: sc + 65 + 32'(pat.size() - 64)});
    end
    foreach (pat[i]) begin
      if (!ended) begin
        w_valid = pat[i];
        w_data  = pat[i] ? w[acc] : 32'($urandom);
        if (pat[i] && acc == abort_at) abort = 1'b1;
        if (pat[i] && acc == rst_at) rst = 1'b1;
        if (pat[i] && acc == spur_at) start = 1'b1;
        @(negedge clk);
        chk("w_ready_in_round", 256'(w_ready), 256'(1));
        chk("round_idx", 256'(round_idx), 256'(acc));
        @(posedge clk);
        #1;
        start = 1'b0;
        if (abort || rst) begin
          if (rst) h_model = IV_C;
          abort = 1'b0;
          rst = 1'b0;
          w_valid = 1'b0;
          check_quiet(abort_at >= 0 ? "abort" : "reset", h_model);
          @(posedge clk);
          #1;
          ended = 1'b1;
        end else if (pat[i]) begin
          acc++;
        end
      end
    end
    if (!ended) begin
      w_valid = 1'b0;
      @(negedge clk);
      chk("final_w_ready", 256'(w_ready), 256'(0));
      chk("final_busy", 256'(busy), 256'(1));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    blk_t abc, empty, two1, two2, rnd;
    init_k();
    h_model = IV_C;
    rst = 1'b1; start = 1'b0; use_iv = 1'b0; abort = 1'b0; w_valid = 1'b0; w_data = '0;
    idle(3);
    rst = 1'b0;
    check_quiet("reset", IV_C);
    idle(1);

    foreach (abc[i]) begin abc[i] = '0; empty[i] = '0; two2[i] = '0; end
    abc[0] = 32'h61626380; abc[15] = 32'h00000018;
    empty[0] = 32'h80000000;
    two1 = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
             32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
             32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
             32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    two2[15] = 32'h000001c0;

    run_block(abc, 1'b1, 1'b0, -1, -1, -1);
    chk("abc_digest", digest, D_ABC);
    idle(2);
    chk("w_ready_idle", 256'(w_ready), 256'(0));

    run_block(empty, 1'b1, 1'b0, -1, -1, -1);
    chk("empty_digest", digest, D_EMPTY);
    idle(2);

    run_block(two1, 1'b1, 1'b0, -1, -1, -1);
    run_block(two2, 1'b0, 1'b0, -1, -1, -1);
    chk("two_block_digest", digest, D_TWO);
    idle(2);

    run_block(abc, 1'b1, 1'b1, -1, -1, -1);
    chk("abc_stall_digest", digest, D_ABC);
    idle(2);

    run_block(empty, 1'b1, 1'b0, 30, -1, -1);
    run_block(abc, 1'b1, 1'b0, -1, -1, -1);
    chk("abc_after_abort_digest", digest, D_ABC);
    idle(2);

    run_block(abc, 1'b1, 1'b1, -1, -1, 10);
    chk("abc_spurious_start_digest", digest, D_ABC);
    idle(2);

    run_block(abc, 1'b1, 1'b0, -1, 40, -1);
    idle(1);

    for (int n = 0; n < 4; n++) begin
      foreach (rnd[i]) rnd[i] = $urandom;
      run_block(rnd, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), -1, -1, -1);
      if ($urandom_range(0, 1) == 0) idle(2);
    end
    idle(4);
    chk("scoreboard_drained", 256'(exp_q.size()), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
